uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
// Byte buffer and launch controller directly upstream of the UART TX controller.
// Host logic pushes bytes into a circular FIFO at any rate. The feeder issues a
// one-cycle Data_Valid with P_DATA to the TX path whenever the FIFO holds data and
// the TX path is idle. It holds P_DATA stable for the whole frame and pops the
// entry only when the TX reports the frame complete (Busy falling).
// PARAMETERS
// DATA_WIDTH  8  width of one character / P_DATA
// ADDR_WIDTH  3  FIFO depth = 2**ADDR_WIDTH entries (8)
// PORTS
// clk         in   1             single clock; all logic on posedge
// RST         in   1             synchronous, active-high reset
// Wr_En       in   1             host push strobe, one byte per cycle
// Wr_Data     in   DATA_WIDTH    host byte, sampled when Wr_En=1
// Full        out  1             FIFO holds 2**ADDR_WIDTH entries (registered)
// Empty       out  1             FIFO holds 0 entries (registered)
// Count       out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
// Overflow    out  1             one-cycle pulse: push dropped because Full
// Busy        in   1             from TX controller: high while a frame is on the line
// Data_Valid  out  1             one-cycle launch strobe to TX controller
// P_DATA      out  DATA_WIDTH    head-of-FIFO byte; stable from launch until pop
// BEHAVIOUR
// - Reset (RST=1 at posedge): wr/rd pointers=0, Count=0, Empty=1, Full=0,
//   Overflow=0, Data_Valid=0, P_DATA=0, state=IDLE. Reset mid-frame discards
//   all FIFO contents. The TX controller is not notified.
// - Pointers ADDR_WIDTH bits, natural wrap 2**ADDR_WIDTH-1 -> 0. Count tracks occupancy.
// - Push: Wr_En & !Full -> mem[wr_ptr]<=Wr_Data, wr_ptr++.
//   Wr_En & Full -> byte dropped, no state change, Overflow=1 next cycle.
//   Full is the registered flag. A push while Full is dropped even if a pop occurs
//   in the same cycle.
// - Pop occurs only on the WAIT_DONE->IDLE transition: rd_ptr++.
//   Push+pop in the same cycle -> Count unchanged.
// - Full/Empty/Count update on the same edge as the pointer change.
// - P_DATA = mem[rd_ptr], registered. It is loaded on entry to LAUNCH and is never
//   modified in LAUNCH/WAIT_ACK/WAIT_DONE.
// - FSM:
//   IDLE:      Data_Valid=0. !Empty & !Busy -> LAUNCH (load P_DATA). Else stay.
//   LAUNCH:    Data_Valid=1 for exactly this cycle -> WAIT_ACK.
//   WAIT_ACK:  Busy=1 -> WAIT_DONE. Busy=0 (launch missed) -> LAUNCH (retry,
//              same byte, no pop).
//   WAIT_DONE: Busy=0 -> pop, IDLE. Else stay.
// - Data_Valid is a registered output, asserted only in LAUNCH. It is never high for
//   2 consecutive cycles.
// - Latency: push at edge W into an empty FIFO with TX idle -> Empty=0 after W.
//   IDLE sees it in cycle W+1. Data_Valid=1 in cycle W+2.
// - Back-to-back: Busy falls in cycle F -> pop at end of F. IDLE in F+1.
//   Next Data_Valid in F+2 if !Empty.
// - Busy high in IDLE (external/foreign frame): no launch until Busy=0.
// TESTING
// 1 Reset: RST=1 two cycles with Wr_En=1 -> Count=0, Empty=1, Data_Valid=0,
//   P_DATA=0; bytes ignored.
// 2 Single byte: push 0xA5 at cycle 0, TX model raises Busy 1 cycle after Data_Valid
//   for 10 cycles -> Data_Valid at cycle 2, P_DATA=0xA5 held throughout.
//   Pop after Busy falls; Empty=1.
// 3 Fill: push 0x00..0x08 (9 bytes) with Busy held high -> Full=1 after 8 pushes,
//   Count=8. 9th push gives Overflow pulse. Drained order is 0x00..0x07.
// 4 Wrap: push 5, drain 5, push 6, drain 6 -> output order matches input order
//   across pointer wrap. Count returns to 0.
// 5 Missed ack: TX model ignores first Data_Valid (Busy stays 0) -> retry
//   Data_Valid 2 cycles later, same P_DATA, Count unchanged.
// 6 Reset mid-frame: 3 bytes queued, RST pulse in WAIT_DONE -> state IDLE, Count=0,
//   no further Data_Valid.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// Host/TX-side bundle for the feeder: host push port, FIFO status and TX launch port.
interface uart_tx_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  Wr_En;
    logic [DATA_WIDTH-1:0] Wr_Data;
    logic                  Full;
    logic                  Empty;
    logic [ADDR_WIDTH:0]   Count;
    logic                  Overflow;
    logic                  Busy;
    logic                  Data_Valid;
    logic [DATA_WIDTH-1:0] P_DATA;

    // The feeder itself
    modport slave (
        input  Wr_En, Wr_Data, Busy,
        output Full, Empty, Count, Overflow, Data_Valid, P_DATA
    );

    // Host logic and TX controller together
    modport master (
        output Wr_En, Wr_Data, Busy,
        input  Full, Empty, Count, Overflow, Data_Valid, P_DATA
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Circular byte FIFO plus launch FSM feeding a UART TX controller.
// The head byte is presented on P_DATA with a one-cycle Data_Valid and is only
// popped once the TX controller drops Busy at the end of the frame.
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 RST,
    uart_tx_feeder_if.slave      bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
    logic                  r_full, r_empty, r_ovf, r_dv;
    logic [DATA_WIDTH-1:0] r_pdata;
    logic                  w_push, w_pop, w_load;

    // A push is accepted only against the registered Full flag, even if a pop
    // frees a slot on the same edge.
    assign w_push = bus.Wr_En & ~r_full;

    // Launch FSM next-state: load the head on IDLE->LAUNCH, pop on WAIT_DONE->IDLE
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_empty && !bus.Busy) begin
                    w_next = LAUNCH;
                    w_load = 1'b1;
                end
            end
            LAUNCH:    w_next = WAIT_ACK;
            WAIT_ACK:  w_next = bus.Busy ? WAIT_DONE : LAUNCH;
            WAIT_DONE: begin
                if (!bus.Busy) begin
                    w_next = IDLE;
                    w_pop  = 1'b1;
                end
            end
            default:   w_next = IDLE;
        endcase
    end

    // Occupancy after this edge; simultaneous push and pop cancel out
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // State register; Data_Valid is registered alongside so it is high exactly in LAUNCH
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= IDLE;
            r_dv    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dv    <= (w_next == LAUNCH);
        end
    end

    // Pointers, occupancy and flags all move on the same edge
    always_ff @(posedge clk) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
            r_ovf   <= bus.Wr_En & r_full;
        end
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (!RST && w_push) r_mem[r_wr_ptr] <= bus.Wr_Data;
    end

    // Head byte captured at launch and frozen until the frame completes (retries reuse it)
    always_ff @(posedge clk) begin
        if (RST)         r_pdata <= '0;
        else if (w_load) r_pdata <= r_mem[r_rd_ptr];
    end

    assign bus.Full       = r_full;
    assign bus.Empty      = r_empty;
    assign bus.Count      = r_count;
    assign bus.Overflow   = r_ovf;
    assign bus.Data_Valid = r_dv;
    assign bus.P_DATA     = r_pdata;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: transaction-level model (byte queue + launch/ack/release
// rules) checked every cycle, a small TX controller model, and directed scenarios
// with literal expectations followed by a randomized phase.
module tb_uart_tx_feeder;
    localparam int DW = 8, AW = 3, DEPTH = 8;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    uart_tx_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .RST(RST), .bus(bus));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // mq: bytes stored; m_held: a byte is presented to TX and not yet released;
    // m_strobe: launch strobe this cycle; m_await: strobe just ended, waiting for Busy.
    logic [DW-1:0] mq[$];
    bit            m_ok = 0, m_held = 0, m_strobe = 0, m_await = 0, m_ovf = 0;
    logic [DW-1:0] m_pdata = '0;

    always @(posedge clk) begin : model
        int sz;
        bit busy, full_b, pop, launch;
        if (RST) begin
            mq.delete();
            m_held = 0; m_strobe = 0; m_await = 0; m_ovf = 0; m_pdata = '0; m_ok = 1;
        end else begin
            sz     = mq.size();
            busy   = bus.Busy;
            full_b = (sz == DEPTH);
            pop    = m_held && !m_strobe && !m_await && !busy;
            launch = !m_held && (sz != 0) && !busy;
            m_ovf  = bus.Wr_En && full_b;
            if (launch) begin
                m_pdata = mq[0]; m_held = 1; m_strobe = 1;
            end else if (m_strobe) begin
                m_strobe = 0; m_await = 1;
            end else if (m_await) begin
                m_await = 0; m_strobe = !busy;
            end else if (pop) begin
                m_held = 0;
            end
            if (pop) void'(mq.pop_front());
            if (bus.Wr_En && !full_b) mq.push_back(bus.Wr_Data);
        end
    end

    // Compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_ok) begin
            chk("Data_Valid", bus.Data_Valid, m_strobe);
            chk("P_DATA",     bus.P_DATA,     m_pdata);
            chk("Count",      bus.Count,      mq.size());
            chk("Empty",      bus.Empty,      mq.size() == 0);
            chk("Full",       bus.Full,       mq.size() == DEPTH);
            chk("Overflow",   bus.Overflow,   m_ovf);
        end
    end

    // ---------------- TX controller model ----------------
    // Raises Busy one cycle after an accepted Data_Valid for frame_len cycles
    // (random length when frame_len==0). tx_hold forces a foreign frame.
    // Each ign_req increment makes it ignore one launch.
    int            ign_req = 0, ign_done = 0, frame_len = 10, busy_left = 0;
    bit            tx_hold = 0, start_dly = 0;
    logic [DW-1:0] sent[$];

    always @(negedge clk) begin
        if (tx_hold) begin
            bus.Busy = 1'b1;
        end else begin
            if (start_dly) begin
                start_dly = 0;
                busy_left = (frame_len == 0) ? int'($urandom_range(1, 6)) : frame_len;
            end
            if (busy_left > 0) begin
                bus.Busy = 1'b1;
                busy_left--;
            end else begin
                bus.Busy = 1'b0;
            end
            if (bus.Data_Valid === 1'b1) begin
                if (ign_req != ign_done) ign_done++;
                else begin
                    start_dly = 1;
                    sent.push_back(bus.P_DATA);
                end
            end
        end
    end

    task automatic wait_quiet(input string nm, input int budget);
        int k = 0;
        while (!(bus.Empty && !bus.Busy && !m_held && !bus.Data_Valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " drain"}, k < budget, 1'b1);
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.Wr_En = 1'b1; bus.Wr_Data = d;
        @(negedge clk);
        bus.Wr_En = 1'b0;
    endtask

    initial begin : stim
        int bad, ndv;
        logic [DW-1:0] exp_q[$];

        // 1: reset held two cycles while pushing
        RST = 1'b1; bus.Wr_En = 1'b1; bus.Wr_Data = 8'h3C;
        repeat (2) @(negedge clk);
        chk("t1 Count", bus.Count, 0);
        chk("t1 Empty", bus.Empty, 1);
        chk("t1 Full",  bus.Full, 0);
        chk("t1 DV",    bus.Data_Valid, 0);
        chk("t1 PDATA", bus.P_DATA, 0);
        RST = 1'b0; bus.Wr_En = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1 still empty", bus.Empty, 1);

        // 2: single byte, launch latency and hold
        frame_len = 10;
        bus.Wr_En = 1'b1; bus.Wr_Data = 8'hA5;          // cycle 0
        @(negedge clk); bus.Wr_En = 1'b0;                 // cycle 1
        chk("t2 Empty c1", bus.Empty, 0);
        chk("t2 DV c1", bus.Data_Valid, 0);
        @(negedge clk);                                   // cycle 2
        chk("t2 DV c2", bus.Data_Valid, 1);
        chk("t2 PDATA c2", bus.P_DATA, 8'hA5);
        bad = 0; ndv = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.P_DATA !== 8'hA5) bad++;
            if (bus.Data_Valid) ndv++;
        end
        chk("t2 PDATA held", bad, 0);
        chk("t2 no relaunch", ndv, 0);
        wait_quiet("t2", 50);
        chk("t2 Empty end", bus.Empty, 1);

        // 3: fill past full with TX busy, then drain in order
        tx_hold = 1; repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            bus.Wr_En = 1'b1; bus.Wr_Data = 8'(i);
            if (i == 8) begin
                chk("t3 Full", bus.Full, 1);
                chk("t3 Count", bus.Count, 8);
            end
            @(negedge clk);
        end
        bus.Wr_En = 1'b0;
        chk("t3 Overflow", bus.Overflow, 1);
        @(negedge clk);
        chk("t3 Overflow gone", bus.Overflow, 0);
        sent.delete(); frame_len = 3; tx_hold = 0;
        wait_quiet("t3", 300);
        chk("t3 sent n", sent.size(), 8);
        for (int i = 0; i < 8 && i < sent.size(); i++) chk("t3 order", sent[i], i);

        // 4: wrap the pointers, order preserved
        for (int n = 5; n <= 6; n++) begin
            sent.delete(); exp_q.delete();
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(8'(8'h40 + 16 * n + i));
                push(8'(8'h40 + 16 * n + i));
            end
            wait_quiet("t4", 300);
            chk("t4 sent n", sent.size(), n);
            for (int i = 0; i < n && i < sent.size(); i++) chk("t4 order", sent[i], exp_q[i]);
            chk("t4 Count", bus.Count, 0);
        end

        // 5: first launch ignored -> retry two cycles later, same byte
        ign_req++;
        bus.Wr_En = 1'b1; bus.Wr_Data = 8'h5A;           // cycle 0
        @(negedge clk); bus.Wr_En = 1'b0;                 // cycle 1
        @(negedge clk);                                   // cycle 2
        chk("t5 DV first", bus.Data_Valid, 1);
        chk("t5 PDATA first", bus.P_DATA, 8'h5A);
        @(negedge clk);                                   // cycle 3
        chk("t5 DV gap", bus.Data_Valid, 0);
        @(negedge clk);                                   // cycle 4
        chk("t5 DV retry", bus.Data_Valid, 1);
        chk("t5 PDATA retry", bus.P_DATA, 8'h5A);
        chk("t5 Count", bus.Count, 1);
        wait_quiet("t5", 100);

        // 6: reset while a frame is in flight discards the queue
        frame_len = 20;
        push(8'h11); push(8'h22); push(8'h33);
        repeat (6) @(negedge clk);
        RST = 1'b1; @(negedge clk); RST = 1'b0;
        chk("t6 Count", bus.Count, 0);
        chk("t6 Empty", bus.Empty, 1);
        chk("t6 DV", bus.Data_Valid, 0);
        ndv = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Data_Valid) ndv++;
        end
        chk("t6 no launch", ndv, 0);

        // random traffic: bursts, foreign frames, missed acks
        frame_len = 0;
        for (int c = 0; c < 600; c++) begin
            bus.Wr_En   = ($urandom_range(0, 99) < 40);
            bus.Wr_Data = 8'($urandom);
            if ($urandom_range(0, 49) == 0) tx_hold = !tx_hold;
            if ($urandom_range(0, 39) == 0) ign_req++;
            @(negedge clk);
        end
        bus.Wr_En = 1'b0; tx_hold = 0;
        wait_quiet("rand", 500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
